// File: rtl/timer_pkg.sv
// Shared constants, state type and digit helpers for the MM:SS countdown timer.
package timer_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    // Digit positions within preset/digits, least significant first
    localparam int unsigned SEC_ONES_IDX = 0;
    localparam int unsigned SEC_TENS_IDX = 1;
    localparam int unsigned MIN_ONES_IDX = 2;
    localparam int unsigned MIN_TENS_IDX = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] digit_max(input int unsigned idx);
        return (idx == SEC_TENS_IDX) ? SEC_TENS_MAX : DIGIT_MAX;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                     input logic [BCD_W-1:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/sec_tick_sync.sv
// Synchronizes the 1 Hz square wave and emits a one-cycle tick per rising edge.
module sec_tick_sync (
    input  logic clock,
    input  logic reset,
    input  logic sec_clk,
    output logic tick
);

    logic s1;
    logic s2;
    logic s3;

    // All flops reset high so a wave already high at release is not seen as an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= sec_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with start/pause/load control and a one-cycle expiry pulse.
module countdown_timer
    import timer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sec_clk,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse
);

    state_t      state;
    state_t      state_n;
    logic [15:0] digits_n;
    logic [15:0] preset_clamped;
    logic [15:0] digits_dec;
    logic        pulse_n;
    logic        tick;
    logic        borrow;
    logic        start_only;
    logic        pause_only;

    sec_tick_sync u_sec_tick_sync (
        .clock   (clock),
        .reset   (reset),
        .sec_clk (sec_clk),
        .tick    (tick)
    );

    always_comb begin
        preset_clamped = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            preset_clamped[i*BCD_W +: BCD_W] = clamp_digit(preset[i*BCD_W +: BCD_W], digit_max(i));
        end
    end

    // Borrow ripples upward from sec_ones; a zero digit wraps to its own maximum
    always_comb begin
        digits_dec = digits;
        borrow     = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (digits[i*BCD_W +: BCD_W] == '0) begin
                    digits_dec[i*BCD_W +: BCD_W] = digit_max(i);
                end else begin
                    digits_dec[i*BCD_W +: BCD_W] = digits[i*BCD_W +: BCD_W] - BCD_W'(1);
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        digits_n   = digits;
        pulse_n    = 1'b0;
        start_only = start & ~pause;
        pause_only = pause & ~start;
        // A tick is consumed only when no control transition happens this cycle
        if (load) begin
            digits_n = preset_clamped;
            state_n  = IDLE;
        end else if (start_only && state == IDLE && digits != '0) begin
            state_n = RUN;
        end else if (start_only && state == PAUSE) begin
            state_n = RUN;
        end else if (pause_only && state == RUN) begin
            state_n = PAUSE;
        end else if (state == RUN && tick) begin
            if (digits == 16'h0001) begin
                digits_n = '0;
                state_n  = EXPIRED;
                pulse_n  = 1'b1;
            end else begin
                digits_n = digits_dec;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            digits       <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            digits       <= digits_n;
            running      <= (state_n == RUN);
            expired      <= (state_n == EXPIRED);
            expire_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer against a seconds-count reference model.
module tb_countdown_timer;

    logic        clock;
    logic        reset;
    logic        sec_clk;
    logic        load;
    logic        start;
    logic        pause;
    logic [15:0] preset;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        expire_pulse;

    int checks;
    int errors;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    int   m_state;
    int   m_secs;
    logic m_pulse;
    int   edge_n;
    int   tick_q[$];
    logic prev_sc;
    int   pulse_seen;

    countdown_timer dut (
        .clock        (clock),
        .reset        (reset),
        .sec_clk      (sec_clk),
        .load         (load),
        .start        (start),
        .pause        (pause),
        .preset       (preset),
        .digits       (digits),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not complete");
        $fatal(1);
    end

    function automatic logic [15:0] bcd_of(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int mt;
        int mo;
        int st;
        int so;
        mt = int'(p[15:12]); if (mt > 9) mt = 9;
        mo = int'(p[11:8]);  if (mo > 9) mo = 9;
        st = int'(p[7:4]);   if (st > 5) st = 5;
        so = int'(p[3:0]);   if (so > 9) so = 9;
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model;
        check("digits", digits, bcd_of(m_secs));
        check("running", 16'(running), 16'(m_state == M_RUN));
        check("expired", 16'(expired), 16'(m_state == M_EXP));
        check("expire_pulse", 16'(expire_pulse), 16'(m_pulse));
    endtask

    task automatic step(input logic ld, input logic st, input logic pa,
                        input logic sc, input logic [15:0] pr);
        bit tk;
        bit moved;
        @(negedge clock);
        load = ld; start = st; pause = pa; sec_clk = sc; preset = pr;
        tk    = 1'b0;
        moved = 1'b0;
        if (tick_q.size() > 0 && tick_q[0] == edge_n) begin
            tk = 1'b1;
            void'(tick_q.pop_front());
        end
        // First edge that samples the new high level is edge_n; digits move two edges later
        if (sc && !prev_sc) tick_q.push_back(edge_n + 2);
        prev_sc = sc;
        m_pulse = 1'b0;
        if (ld) begin
            m_secs  = preset_secs(pr);
            m_state = M_IDLE;
        end else begin
            if (st && !pa) begin
                if (m_state == M_IDLE && m_secs != 0) begin
                    m_state = M_RUN; moved = 1'b1;
                end else if (m_state == M_PAUSE) begin
                    m_state = M_RUN; moved = 1'b1;
                end
            end else if (pa && !st && m_state == M_RUN) begin
                m_state = M_PAUSE; moved = 1'b1;
            end
            if (!moved && m_state == M_RUN && tk) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_state = M_EXP;
                    m_pulse = 1'b1;
                end
            end
        end
        @(posedge clock);
        edge_n++;
        #1;
        if (expire_pulse) pulse_seen++;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digits"}, digits, 16'h0000);
        check({tag, "_running"}, 16'(running), 16'h0);
        check({tag, "_expired"}, 16'(expired), 16'h0);
        check({tag, "_pulse"}, 16'(expire_pulse), 16'h0);
    endtask

    task automatic do_reset(input logic sc);
        @(negedge clock);
        load = 1'b0; start = 1'b0; pause = 1'b0; sec_clk = sc;
        #3 reset = 1'b0;
        #1 check_reset_values("reset_async");
        m_state = M_IDLE;
        m_secs  = 0;
        m_pulse = 1'b0;
        tick_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset   = 1'b1;
        prev_sc = sc;
    endtask

    task automatic sec_pulses(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            repeat (half) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            repeat (half) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        edge_n = 0; pulse_seen = 0;
        m_state = M_IDLE; m_secs = 0; m_pulse = 1'b0; prev_sc = 1'b1;
        reset = 1'b1; sec_clk = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; preset = '0;

        // Reset with sec_clk already high: no tick afterwards
        do_reset(1'b1);
        repeat (100) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("idle_after_reset_digits", digits, 16'h0000);

        // 00:03 counts down and expires
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        pulse_seen = 0;
        sec_pulses(3, 4);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("expire_pulse_count", 16'(pulse_seen), 16'd1);
        check("expired_hold", 16'(expired), 16'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("start_in_expired", 16'(expired), 16'h1);

        // Borrow chain
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        sec_pulses(1, 4);
        check("borrow_chain", digits, 16'h0959);

        // Pause lands on the tick edge: tick discarded
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        check("pause_tick_digits", digits, 16'h0100);
        check("pause_tick_running", 16'(running), 16'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        check("start_pause_same", 16'(running), 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("resume", 16'(running), 16'h1);
        sec_pulses(2, 5);
        check("resume_count", digits, 16'h0058);

        // Clamp and zero-start
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h9F7C);
        check("clamp", digits, 16'h9959);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("zero_start_running", 16'(running), 16'h0);

        // Reset mid-count at 05:30
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0530);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("pre_reset_digits", digits, 16'h0530);
        do_reset(1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);

        // Randomized control traffic against the model
        begin
            int   half;
            int   cnt;
            logic sc;
            int   r;
            logic [15:0] pr;
            half = 4; cnt = 0; sc = 1'b1;
            for (int n = 0; n < 600; n++) begin
                if (cnt >= half) begin
                    sc   = ~sc;
                    cnt  = 0;
                    half = $urandom_range(3, 7);
                end
                cnt++;
                r  = $urandom_range(0, 99);
                pr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 40));
                if (r < 3)       step(1'b1, 1'b0, 1'b0, sc, pr);
                else if (r < 10) step(1'b0, 1'b1, 1'b0, sc, 16'h0);
                else if (r < 13) step(1'b0, 1'b0, 1'b1, sc, 16'h0);
                else             step(1'b0, 1'b0, 1'b0, sc, 16'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds countdown timer that directly consumes the 1 Hz square wave from the frequency divider. It detects each rising edge of that wave as a one-second tick and decrements a 4-digit BCD value (MM:SS). Start, pause and load controls come from debounced buttons. It drives the seven-segment digit decoder and raises a one-cycle expiry pulse for the buzzer/LED stage.

## Interface
- No parameters; digit widths and limits are package constants.
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- sec_clk  in  1  1 Hz square wave from the divider; rising edge = one second
- load  in  1  one-cycle pulse: copy preset into digits, go IDLE
- start  in  1  one-cycle pulse: begin/resume counting
- pause  in  1  one-cycle pulse: freeze counting
- preset  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
- digits  out  16  current BCD value, same packing as preset
- running  out  1  high while state = RUN
- expired  out  1  high while state = EXPIRED
- expire_pulse  out  1  one-cycle pulse on reaching 00:00 from RUN

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- IDLE --start, digits≠0--> RUN. If digits=0, start is ignored.
- RUN --pause--> PAUSE. PAUSE --start--> RUN.
- RUN, tick, digits=00:01 --> EXPIRED. digits become 0000 and expire_pulse fires.
- load in any state sets digits = clamped preset and goes to IDLE.
- Priority: load > (start, pause) > tick.
- start and pause in the same cycle: no state change.
- start or pause in a state where it has no transition: ignored.
- EXPIRED is left only via load (or reset). Start is ignored in EXPIRED.
- Preset clamping per digit:
  - sec_tens > 5 → 5
  - any other digit > 9 → 9
  - e.g. preset 16'h9F7C loads 16'h9959.
- Decrement happens only in RUN on a tick. It uses a borrow chain:
  - sec_ones 0→9 borrows from sec_tens
  - sec_tens 0→5 borrows from min_ones
  - min_ones 0→9 borrows from min_tens
  - Example: 10:00 → 09:59.
- A tick in the same cycle as pause, or as start from PAUSE, is discarded.
- A tick outside RUN is discarded.

## Timing
- sec_clk passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
- tick = s2 & ~s3.
- Let k be the first clock edge at which s1 samples sec_clk = 1. Then:
  - tick is high between edges k+1 and k+2
  - digits update at edge k+2
- expire_pulse and expired go high at the same edge at which digits become 0000.
- expire_pulse lasts exactly one cycle.
- running and expired are registered, decoded from the state register. They change at the same edge as the state.
- load takes effect at the next edge: digits = clamped preset on the following cycle.
- Reset (asynchronous, active-low) values:
  - digits = 16'h0000
  - state = IDLE
  - running = 0, expired = 0, expire_pulse = 0
  - s1, s2 and s3 all = 1, so a sec_clk that is already high at reset release produces no tick.
- Reset mid-count discards the count immediately. No tick is produced until the next genuine rising edge of sec_clk.

## Structure
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, EXPIRED)
  - BCD_W = 4
  - SEC_TENS_MAX = 5, DIGIT_MAX = 9
  - digit index constants for the preset/digits packing
- Sub-module sec_tick_sync:
  - contains the synchronizer and edge detector
  - ports: clock, reset, sec_clk, tick
  - reset values as above
- The state machine, clamping and borrow chain live in countdown_timer.

## Test plan
- Reset with sec_clk held high, then release; sec_clk stays high for 100 cycles → no tick, digits = 0000, state IDLE.
- load preset 16'h0003, start, 3 sec_clk rising edges:
  - digits go 0002, 0001, 0000, each at the k+2 edge
  - expire_pulse high exactly 1 cycle
  - expired stays high afterwards
- Borrow chain: load 16'h1000, start, one tick → digits = 16'h0959.
- Simultaneous events:
  - pause coinciding with tick → digits unchanged, state PAUSE
  - start and pause in the same cycle → no change
  - start in EXPIRED → ignored
- Clamp, and zero-start:
  - load 16'h9F7C → digits = 16'h9959
  - load 16'h0000 then start → state stays IDLE, running = 0
- Mid-operation reset: assert reset during RUN at 05:30 → all outputs return to their reset values within the same cycle.
